// File: rtl/ysyx_25030093_csr_unit_if.sv
// Purpose: bundles the pipeline <-> machine-mode CSR unit signals (CSR access, trap/mret, redirect).
// Latency: pure wiring; every field is sampled or produced by the CSR unit in the same cycle.
// Backpressure: none; in_valid qualifies a commit that the CSR unit always accepts.
//
// Ports (all carried inside the interface; master = pipeline, slave = CSR unit):
//   in_valid, csr_op, csr_addr, csr_wsrc          access request from the commit point
//   csr_rdata, csr_illegal                        combinational read result / legality
//   trap_valid, trap_cause, trap_pc, mret, retire trap / return / retirement events
//   redirect_valid, redirect_pc, mstatus_mie      control-flow redirect and interrupt enable
interface ysyx_25030093_csr_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wsrc;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            trap_valid;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic            mret;
    logic            retire;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mstatus_mie;

    modport master (
        output in_valid,
        output csr_op,
        output csr_addr,
        output csr_wsrc,
        input  csr_rdata,
        input  csr_illegal,
        output trap_valid,
        output trap_cause,
        output trap_pc,
        output mret,
        output retire,
        input  redirect_valid,
        input  redirect_pc,
        input  mstatus_mie
    );

    modport slave (
        input  in_valid,
        input  csr_op,
        input  csr_addr,
        input  csr_wsrc,
        output csr_rdata,
        output csr_illegal,
        input  trap_valid,
        input  trap_cause,
        input  trap_pc,
        input  mret,
        input  retire,
        output redirect_valid,
        output redirect_pc,
        output mstatus_mie
    );
endinterface

// File: rtl/ysyx_25030093_csr_unit.sv
// Purpose: machine-mode CSR file (Zicsr RMW, trap entry, mret stacking, 64-bit mcycle/minstret).
// Latency: reads/illegal/redirect are combinational; writes visible the cycle after the edge.
// Backpressure: none; every qualified commit is absorbed in the cycle it is presented.
//
// Ports:
//   clock  rising-edge clock for all state
//   reset  synchronous active-high initialisation
//   bus    ysyx_25030093_csr_unit_if.slave (access, trap/mret/retire in; rdata, illegal, redirect out)
module ysyx_25030093_csr_unit #(
    // Only 32 is supported: counters are exposed as two XLEN-wide halves.
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET   = 32'h0,
    parameter logic [XLEN-1:0] MSTATUS_RESET = 32'h1800,
    parameter logic [XLEN-1:0] HARTID        = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    ysyx_25030093_csr_unit_if.slave   bus
);

    // ------------------------------------------------------------------
    // Address map and op encoding
    // ------------------------------------------------------------------
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] MARCHID_VAL = 'h19D;
    // Clears the two low bits of mtvec/mepc (direct mode, 4-byte aligned pcs).
    localparam logic [XLEN-1:0] ALIGN_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [2*XLEN-1:0] CNT_ONE   = {{(2*XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    // Only M-mode exists, so MPP is hardwired to 2'b11 and not stored.
    logic              mie_q;
    logic              mpie_q;
    logic [XLEN-1:0]   mtvec_q;
    logic [XLEN-1:0]   mscratch_q;
    logic [XLEN-1:0]   mepc_q;
    logic [XLEN-1:0]   mcause_q;
    logic [2*XLEN-1:0] mcycle_q;
    logic [2*XLEN-1:0] minstret_q;

    // ------------------------------------------------------------------
    // Read view and address decode
    // ------------------------------------------------------------------
    csr_op_e         op;
    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] read_val;
    logic            addr_impl;
    logic            addr_ro;
    logic            illegal;
    logic [XLEN-1:0] wdata;

    assign op = csr_op_e'(bus.csr_op);

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[3]     = mie_q;
        mstatus_rd[7]     = mpie_q;
        mstatus_rd[12:11] = 2'b11;
    end

    always_comb begin
        read_val  = '0;
        addr_impl = 1'b1;
        addr_ro   = 1'b0;
        case (bus.csr_addr)
            ADDR_MSTATUS:   read_val = mstatus_rd;
            ADDR_MTVEC:     read_val = mtvec_q;
            ADDR_MSCRATCH:  read_val = mscratch_q;
            ADDR_MEPC:      read_val = mepc_q;
            ADDR_MCAUSE:    read_val = mcause_q;
            ADDR_MCYCLE:    read_val = mcycle_q[XLEN-1:0];
            ADDR_MCYCLEH:   read_val = mcycle_q[2*XLEN-1:XLEN];
            ADDR_MINSTRET:  read_val = minstret_q[XLEN-1:0];
            ADDR_MINSTRETH: read_val = minstret_q[2*XLEN-1:XLEN];
            ADDR_MVENDORID: begin
                read_val = '0;
                addr_ro  = 1'b1;
            end
            ADDR_MARCHID: begin
                read_val = MARCHID_VAL;
                addr_ro  = 1'b1;
            end
            ADDR_MHARTID: begin
                read_val = HARTID;
                addr_ro  = 1'b1;
            end
            default: begin
                read_val  = '0;
                addr_impl = 1'b0;
            end
        endcase
    end

    // A read-only CSR is still readable through csrrs/csrrc with a zero
    // source; anything that would actually modify it is illegal.
    always_comb begin
        illegal = 1'b0;
        if (op != OP_NONE) begin
            if (!addr_impl) begin
                illegal = 1'b1;
            end else if (addr_ro && (op == OP_RW || bus.csr_wsrc != '0)) begin
                illegal = 1'b1;
            end
        end
    end

    always_comb begin
        wdata = read_val;
        case (op)
            OP_RW:   wdata = bus.csr_wsrc;
            OP_RS:   wdata = read_val | bus.csr_wsrc;
            OP_RC:   wdata = read_val & ~bus.csr_wsrc;
            default: wdata = read_val;
        endcase
    end

    // ------------------------------------------------------------------
    // Event qualification and priority: trap > mret > CSR write
    // ------------------------------------------------------------------
    logic trap_take;
    logic mret_take;
    logic csr_wen;
    logic wr_mstatus;
    logic wr_mtvec;
    logic wr_mscratch;
    logic wr_mepc;
    logic wr_mcause;
    logic wr_mcycle;
    logic wr_mcycleh;
    logic wr_minstret;
    logic wr_minstreth;

    assign trap_take = bus.in_valid & bus.trap_valid;
    assign mret_take = bus.in_valid & bus.mret & ~bus.trap_valid;

    // Read-only CSRs never write even on a legal zero-source access, and a
    // trap or mret in the same commit drops the CSR write as a whole.
    assign csr_wen = bus.in_valid & (op != OP_NONE) & ~illegal & ~addr_ro
                   & ~bus.trap_valid & ~bus.mret;

    assign wr_mstatus   = csr_wen & (bus.csr_addr == ADDR_MSTATUS);
    assign wr_mtvec     = csr_wen & (bus.csr_addr == ADDR_MTVEC);
    assign wr_mscratch  = csr_wen & (bus.csr_addr == ADDR_MSCRATCH);
    assign wr_mepc      = csr_wen & (bus.csr_addr == ADDR_MEPC);
    assign wr_mcause    = csr_wen & (bus.csr_addr == ADDR_MCAUSE);
    assign wr_mcycle    = csr_wen & (bus.csr_addr == ADDR_MCYCLE);
    assign wr_mcycleh   = csr_wen & (bus.csr_addr == ADDR_MCYCLEH);
    assign wr_minstret  = csr_wen & (bus.csr_addr == ADDR_MINSTRET);
    assign wr_minstreth = csr_wen & (bus.csr_addr == ADDR_MINSTRETH);

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            mie_q      <= MSTATUS_RESET[3];
            mpie_q     <= MSTATUS_RESET[7];
            mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            // mstatus / mepc / mcause: trap stacking beats mret beats write.
            if (trap_take) begin
                mepc_q   <= bus.trap_pc & ALIGN_MASK;
                mcause_q <= bus.trap_cause;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (mret_take) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else begin
                if (wr_mstatus) begin
                    mie_q  <= wdata[3];
                    mpie_q <= wdata[7];
                end
                if (wr_mepc) begin
                    mepc_q <= wdata & ALIGN_MASK;
                end
                if (wr_mcause) begin
                    mcause_q <= wdata;
                end
            end

            if (wr_mtvec) begin
                mtvec_q <= wdata & ALIGN_MASK;
            end
            if (wr_mscratch) begin
                mscratch_q <= wdata;
            end

            // A write to either half replaces it and holds the other half,
            // so software can load a 64-bit value without a racing carry.
            if (wr_mcycle) begin
                mcycle_q[XLEN-1:0] <= wdata;
            end else if (wr_mcycleh) begin
                mcycle_q[2*XLEN-1:XLEN] <= wdata;
            end else begin
                mcycle_q <= mcycle_q + CNT_ONE;
            end

            if (wr_minstret) begin
                minstret_q[XLEN-1:0] <= wdata;
            end else if (wr_minstreth) begin
                minstret_q[2*XLEN-1:XLEN] <= wdata;
            end else if (bus.in_valid && bus.retire) begin
                minstret_q <= minstret_q + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.csr_illegal    = illegal;
    assign bus.csr_rdata      = illegal ? '0 : read_val;
    // Forced low while reset is asserted so a stale trap cannot redirect.
    assign bus.redirect_valid = ~reset & bus.in_valid & (bus.trap_valid | bus.mret);
    assign bus.redirect_pc    = bus.trap_valid ? mtvec_q : mepc_q;
    assign bus.mstatus_mie    = ~reset & mie_q;

endmodule

// File: tb/tb_ysyx_25030093_csr_unit.sv
// Purpose: directed self-checking bench for ysyx_25030093_csr_unit with a queue scoreboard.
// Latency: expectations are pushed when a step is driven and popped once outputs settle.
// Backpressure: none; the bench drives one commit per clock.
module tb_ysyx_25030093_csr_unit;

    localparam logic [31:0] HART_ID   = 32'd7;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0013;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    ysyx_25030093_csr_unit_if #(.XLEN(32)) bus();

    ysyx_25030093_csr_unit #(
        .XLEN          (32),
        .MTVEC_RESET   (MTVEC_RST),
        .MSTATUS_RESET (32'h1800),
        .HARTID        (HART_ID)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic push(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.csr_op     = 2'b00;
        bus.csr_addr   = 12'h000;
        bus.csr_wsrc   = 32'h0;
        bus.trap_valid = 1'b0;
        bus.trap_cause = 32'h0;
        bus.trap_pc    = 32'h0;
        bus.mret       = 1'b0;
        bus.retire     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    // Combinational read in the current cycle; no state change.
    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] e);
        bus.csr_op   = 2'b00;
        bus.csr_addr = addr;
        push(tag, e);
        #1;
        pop_check(bus.csr_rdata);
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src);
        bus.in_valid = 1'b1;
        bus.csr_op   = op;
        bus.csr_addr = addr;
        bus.csr_wsrc = src;
    endtask

    initial begin
        idle();
        // Reset cycle with a trap presented: no redirect, no trap recorded.
        reset          = 1'b1;
        bus.in_valid   = 1'b1;
        bus.trap_valid = 1'b1;
        bus.trap_cause = 32'd5;
        bus.trap_pc    = 32'h200;
        @(posedge clock);
        #1;
        push("rst_redirect_valid", 32'd0);
        push("rst_mie", 32'd0);
        pop_check({31'b0, bus.redirect_valid});
        pop_check({31'b0, bus.mstatus_mie});
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle();

        rd("rst_mtvec", 12'h305, MTVEC_RST & ~32'h3);
        rd("rst_mstatus", 12'h300, 32'h1800);
        rd("rst_mcycle", 12'hB00, 32'd0);
        rd("rst_mepc", 12'h341, 32'd0);
        rd("rst_mcause", 12'h342, 32'd0);
        repeat (5) tick();
        rd("mcycle_5", 12'hB00, 32'd5);

        // Basic RW / RS / RC.
        csr(2'b01, 12'h305, 32'h8000_0103);
        push("rw_mtvec_legal", 32'd0);
        #1;
        pop_check({31'b0, bus.csr_illegal});
        tick();
        rd("mtvec_rw", 12'h305, 32'h8000_0100);
        csr(2'b10, 12'h300, 32'h8);
        tick();
        rd("mstatus_rs", 12'h300, 32'h1808);
        push("mie_after_rs", 32'd1);
        pop_check({31'b0, bus.mstatus_mie});
        csr(2'b11, 12'h300, 32'h8);
        tick();
        rd("mstatus_rc", 12'h300, 32'h1800);
        csr(2'b10, 12'h300, 32'h8);
        tick();

        // Trap entry then mret.
        bus.in_valid   = 1'b1;
        bus.trap_valid = 1'b1;
        bus.trap_cause = 32'd11;
        bus.trap_pc    = 32'h8000_0046;
        push("trap_redirect_valid", 32'd1);
        push("trap_redirect_pc", 32'h8000_0100);
        #1;
        pop_check({31'b0, bus.redirect_valid});
        pop_check(bus.redirect_pc);
        tick();
        rd("trap_mepc", 12'h341, 32'h8000_0044);
        rd("trap_mcause", 12'h342, 32'd11);
        rd("trap_mstatus", 12'h300, 32'h1880);
        push("trap_mie", 32'd0);
        pop_check({31'b0, bus.mstatus_mie});
        bus.in_valid = 1'b1;
        bus.mret     = 1'b1;
        push("mret_redirect_valid", 32'd1);
        push("mret_redirect_pc", 32'h8000_0044);
        #1;
        pop_check({31'b0, bus.redirect_valid});
        pop_check(bus.redirect_pc);
        tick();
        rd("mret_mstatus", 12'h300, 32'h1888);

        // Trap and mret each suppress a same-cycle CSR write.
        csr(2'b01, 12'h341, 32'h1234);
        bus.trap_valid = 1'b1;
        bus.trap_cause = 32'd11;
        bus.trap_pc    = 32'h100;
        tick();
        rd("trapwr_mepc", 12'h341, 32'h100);
        rd("trapwr_mstatus", 12'h300, 32'h1880);
        csr(2'b01, 12'h340, 32'hAA);
        bus.mret = 1'b1;
        tick();
        rd("mretwr_mscratch", 12'h340, 32'h0);
        rd("mretwr_mstatus", 12'h300, 32'h1888);
        csr(2'b01, 12'h341, 32'h1237);
        tick();
        rd("mepc_align", 12'h341, 32'h1234);

        // Illegal and read-only accesses.
        csr(2'b01, 12'hF11, 32'h5);
        push("rw_ro_illegal", 32'd1);
        push("rw_ro_rdata", 32'd0);
        #1;
        pop_check({31'b0, bus.csr_illegal});
        pop_check(bus.csr_rdata);
        tick();
        rd("mvendorid", 12'hF11, 32'd0);
        csr(2'b10, 12'hF14, 32'h0);
        push("rs0_hartid_legal", 32'd0);
        push("rs0_hartid_rdata", HART_ID);
        #1;
        pop_check({31'b0, bus.csr_illegal});
        pop_check(bus.csr_rdata);
        bus.csr_addr = 12'hF12;
        push("marchid", 32'h19D);
        #1;
        pop_check(bus.csr_rdata);
        bus.csr_op   = 2'b11;
        bus.csr_wsrc = 32'h1;
        push("rc_ro_illegal", 32'd1);
        #1;
        pop_check({31'b0, bus.csr_illegal});
        bus.csr_op   = 2'b10;
        bus.csr_addr = 12'h7C0;
        bus.csr_wsrc = 32'h0;
        push("unimpl_illegal", 32'd1);
        push("unimpl_rdata", 32'd0);
        #1;
        pop_check({31'b0, bus.csr_illegal});
        pop_check(bus.csr_rdata);
        tick();

        // 64-bit wrap of mcycle.
        csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        tick();
        csr(2'b01, 12'hB80, 32'hFFFF_FFFF);
        tick();
        rd("mcycle_max_lo", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycle_max_hi", 12'hB80, 32'hFFFF_FFFF);
        tick();
        rd("mcycle_wrap_lo", 12'hB00, 32'd0);
        rd("mcycle_wrap_hi", 12'hB80, 32'd0);

        // minstret counts only qualified retirements.
        rd("minstret_start", 12'hB02, 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.retire   = 1'b1;
            tick();
        end
        bus.retire = 1'b1;
        tick();
        rd("minstret_3", 12'hB02, 32'd3);
        rd("minstreth_0", 12'hB82, 32'd0);
        csr(2'b01, 12'hB02, 32'h10);
        bus.retire = 1'b1;
        tick();
        rd("minstret_write_wins", 12'hB02, 32'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
